// File: rtl/gain_ramp_amplifier.sv
// -----------------------------------------------------------------------------
// gain_ramp_amplifier
//
// Per-band gain stage that sits between the band filters and the band summer.
// A frame holds one signed sample per band. The bands are processed one per
// cycle through a single shared multiplier. Each band's working gain moves
// toward its target by at most RAMP_STEP LSBs per frame, so a gain change
// does not produce zipper noise. Results are saturated to the sample width.
// The rounding is selectable: floor, or round-half-up. Each band has a sticky
// saturation flag.
//
// Ports
//   i_clk                  clock
//   i_rst                  synchronous active-high reset
//   i_en                   1 = amplify, 0 = bypass; captured when a frame is accepted
//   i_gains_valid          load i_gains into the per-band target registers
//   i_gains                packed signed target gains, band i at [(i+1)*G-1:i*G]
//   i_in_valid             a frame of band samples is offered
//   o_in_ready             block is idle and can accept a frame
//   i_filter_ins           packed signed band samples, band i at [(i+1)*W-1:i*W]
//   o_out_valid            one-cycle pulse: o_amplified_filter_ins holds a new frame
//   o_amplified_filter_ins packed signed results, held until the next frame
//   o_sat_flags            sticky per-band saturation indicators
//   i_sat_clear            clear all saturation flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module gain_ramp_amplifier #(
  parameter int NUMBER_OF_FILTERS = 8,
  parameter int FILTER_IN_BITS    = 16,
  parameter int GAIN_BITS         = 8,
  parameter int GAIN_FRAC_BITS    = 2,
  parameter int RAMP_STEP         = 1,
  parameter int ROUND_MODE        = 0
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic                                        i_en,
  input  logic                                        i_gains_valid,
  input  logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0]      i_gains,
  input  logic                                        i_in_valid,
  output logic                                        o_in_ready,
  input  logic [NUMBER_OF_FILTERS*FILTER_IN_BITS-1:0] i_filter_ins,
  output logic                                        o_out_valid,
  output logic [NUMBER_OF_FILTERS*FILTER_IN_BITS-1:0] o_amplified_filter_ins,
  output logic [NUMBER_OF_FILTERS-1:0]                o_sat_flags,
  input  logic                                        i_sat_clear
);

  localparam int N     = NUMBER_OF_FILTERS;
  localparam int W     = FILTER_IN_BITS;
  localparam int G     = GAIN_BITS;
  localparam int F     = GAIN_FRAC_BITS;
  localparam int PW    = W + G;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Half an output LSB, added before the fraction bits are dropped when rounding.
  localparam int              RND_SH  = (F > 0) ? F - 1 : 0;
  localparam logic [PW:0]     RND_ADD = (ROUND_MODE == 1 && F > 0) ? ((PW+1)'(1) << RND_SH) : '0;

  // A step larger than any possible gain difference behaves the same as the
  // largest difference, so the step is capped to stay inside G+1 signed bits.
  localparam int               STEP_LIM = (RAMP_STEP > (1 << G) - 1) ? (1 << G) - 1 : RAMP_STEP;
  localparam logic signed [G:0] STEP_S  = (G+1)'(STEP_LIM);
  localparam logic [G-1:0]     STEP_G   = STEP_S[G-1:0];

  localparam logic [G-1:0]     UNITY    = G'(1 << F);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [W-1:0]     SAT_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     SAT_MIN  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_in_ready;

  logic [IDX_W-1:0] r_idx;
  logic             r_en;
  logic             r_out_valid;

  logic w_accept;
  logic w_mul;
  logic w_last;

  // Per-band registers live in the generate loop; these flat buses collect
  // them so the shared datapath can select the active band by index.
  logic [N*W-1:0] w_sample_flat;
  logic [N*G-1:0] w_gain_flat;
  logic [N*G-1:0] w_target_flat;
  logic [N*W-1:0] w_res_flat;

  logic signed [W-1:0]  w_sample;
  logic signed [G-1:0]  w_gain;
  logic signed [G-1:0]  w_target;
  logic signed [PW-1:0] w_product;
  logic [PW:0]          w_rounded;
  logic [G-F+1:0]       w_hi;
  logic                 w_ovf;
  logic [W-1:0]         w_amp;
  logic [W-1:0]         w_result;
  logic                 w_sat_set;
  logic signed [G:0]    w_diff;
  logic signed [G-1:0]  w_gain_next;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (i_in_valid) begin
          w_state_next = S_MUL;
        end
      end
      S_MUL: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_accept = i_in_valid && w_in_ready;
  assign w_mul    = (r_state == S_MUL);
  assign w_last   = w_mul && (r_idx == LAST_IDX);

  // The output frame is written on the last multiply edge, so out_valid and
  // the new data are both visible during the DONE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx       <= '0;
      r_en        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_last;
      if (w_accept) begin
        r_idx <= '0;
        r_en  <= i_en;
      end else if (w_mul) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shared datapath for the band selected by r_idx
  // ---------------------------------------------------------------------------
  assign w_sample = w_sample_flat[int'(r_idx)*W +: W];
  assign w_gain   = w_gain_flat[int'(r_idx)*G +: G];
  assign w_target = w_target_flat[int'(r_idx)*G +: G];

  // Sign-extend both operands so the full signed product fits in W+G bits.
  assign w_product = PW'(w_sample) * PW'(w_gain);

  // One extra bit so adding the rounding constant cannot wrap.
  assign w_rounded = {w_product[PW-1], w_product} + RND_ADD;

  // The result fits only if every bit above the kept field repeats its sign.
  assign w_hi  = w_rounded[PW:F+W-1];
  assign w_ovf = ~((&w_hi) | ~(|w_hi));
  assign w_amp = w_ovf ? (w_rounded[PW] ? SAT_MIN : SAT_MAX) : w_rounded[F+W-1:F];

  // Bypass passes the sample through unchanged and never flags saturation.
  assign w_result  = r_en ? w_amp : w_sample;
  assign w_sat_set = r_en && w_ovf;

  // Gain ramp: move toward the target by the step, or land on it exactly
  // when it is closer than one step.
  assign w_diff = {w_target[G-1], w_target} - {w_gain[G-1], w_gain};

  always_comb begin
    w_gain_next = w_target;
    if (w_diff > STEP_S) begin
      w_gain_next = w_gain + STEP_G;
    end else if (w_diff < -STEP_S) begin
      w_gain_next = w_gain - STEP_G;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-band state
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_band
      logic signed [W-1:0] r_sample;
      logic signed [G-1:0] r_cur_gain;
      logic signed [G-1:0] r_target;
      logic [W-1:0]        r_res;
      logic [W-1:0]        r_out;
      logic                r_sat_flag;
      logic                w_sel;

      assign w_sel = w_mul && (r_idx == IDX_W'(gi));

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_sample   <= '0;
          r_cur_gain <= UNITY;
          r_target   <= UNITY;
          r_res      <= '0;
          r_out      <= '0;
          r_sat_flag <= 1'b0;
        end else begin
          if (w_accept) begin
            r_sample <= i_filter_ins[gi*W +: W];
          end
          // Targets load in any state. A band that has already been processed
          // this frame sees the new target only in the next frame.
          if (i_gains_valid) begin
            r_target <= i_gains[gi*G +: G];
          end
          if (w_sel) begin
            r_cur_gain <= w_gain_next;
            r_res      <= w_result;
          end
          // The last band's result is still on the datapath at this edge.
          if (w_last) begin
            r_out <= (gi == N - 1) ? w_result : r_res;
          end
          if (w_sel && w_sat_set) begin
            r_sat_flag <= 1'b1;
          end else if (i_sat_clear) begin
            r_sat_flag <= 1'b0;
          end
        end
      end

      assign w_sample_flat[gi*W +: W]          = r_sample;
      assign w_gain_flat[gi*G +: G]            = r_cur_gain;
      assign w_target_flat[gi*G +: G]          = r_target;
      assign w_res_flat[gi*W +: W]             = r_res;
      assign o_amplified_filter_ins[gi*W +: W] = r_out;
      assign o_sat_flags[gi]                   = r_sat_flag;
    end
  endgenerate

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_gain_ramp_amplifier.sv
// -----------------------------------------------------------------------------
// tb_gain_ramp_amplifier
//
// Two instances share the same stimulus: one truncates (floor) and one rounds
// half-up. The driver pushes the hand-computed expectation for each accepted
// frame into a queue. A monitor pops one entry on every out_valid and compares
// the latency, each band of both instances, and the saturation flags.
// -----------------------------------------------------------------------------
module tb_gain_ramp_amplifier;

  typedef struct packed {
    logic [127:0] fl;
    logic [127:0] rd;
    logic [7:0]   flags;
    logic [31:0]  cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         en;
  logic         gains_valid;
  logic [63:0]  gains;
  logic         in_valid;
  logic [127:0] filter_ins;
  logic         sat_clear;

  logic         in_ready_f, in_ready_r;
  logic         out_valid_f, out_valid_r;
  logic [127:0] amp_f, amp_r;
  logic [7:0]   flags_f, flags_r;

  gain_ramp_amplifier #(.ROUND_MODE(0)) u_floor (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_gains_valid(gains_valid), .i_gains(gains),
    .i_in_valid(in_valid), .o_in_ready(in_ready_f), .i_filter_ins(filter_ins),
    .o_out_valid(out_valid_f), .o_amplified_filter_ins(amp_f), .o_sat_flags(flags_f),
    .i_sat_clear(sat_clear)
  );

  gain_ramp_amplifier #(.ROUND_MODE(1)) u_round (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_gains_valid(gains_valid), .i_gains(gains),
    .i_in_valid(in_valid), .o_in_ready(in_ready_r), .i_filter_ins(filter_ins),
    .o_out_valid(out_valid_r), .o_amplified_filter_ins(amp_r), .o_sat_flags(flags_r),
    .i_sat_clear(sat_clear)
  );

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   frame_no = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] all16(input logic [15:0] v);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [127:0] put16(input logic [127:0] vec, input int b, input logic [15:0] v);
    logic [127:0] r;
    r = vec;
    r[b*16 +: 16] = v;
    return r;
  endfunction

  // Offer one frame at a negedge; the handshake happens at the next posedge.
  task automatic send_frame(input logic en_v, input logic [127:0] smp, input logic [127:0] efl,
                            input logic [127:0] erd, input logic [7:0] eflags, input bit push,
                            output int t);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready_f) begin
      if (n == 100) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout actual=0 required=1");
        t = cyc;
        return;
      end
      n++;
      @(negedge clk);
    end
    en         = en_v;
    filter_ins = smp;
    in_valid   = 1'b1;
    t          = cyc;
    if (push) begin
      e.fl    = efl;
      e.rd    = erd;
      e.flags = eflags;
      e.cyc   = 32'(t + 9);
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready_f) begin
      if (n == 100) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout actual=0 required=1");
        return;
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic set_gains(input logic [63:0] g);
    wait_idle();
    gains       = g;
    gains_valid = 1'b1;
    @(negedge clk);
    gains_valid = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (out_valid_f || out_valid_r) begin
      frame_no++;
      $display("frame %0d cycle %0d floor=%h round=%h flags=%h/%h",
               frame_no, cyc, amp_f, amp_r, flags_f, flags_r);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid actual=1 required=0 cycle=%0d", cyc);
      end else begin
        e = exp_q.pop_front();
        check("latency_cycle", 128'(cyc), 128'(e.cyc));
        check("out_valid_floor", 128'(out_valid_f), 128'd1);
        check("out_valid_round", 128'(out_valid_r), 128'd1);
        for (int b = 0; b < 8; b++) begin
          check($sformatf("band%0d_floor", b), 128'(amp_f[b*16 +: 16]), 128'(e.fl[b*16 +: 16]));
          check($sformatf("band%0d_round", b), 128'(amp_r[b*16 +: 16]), 128'(e.rd[b*16 +: 16]));
        end
        check("sat_flags_floor", 128'(flags_f), 128'(e.flags));
        check("sat_flags_round", 128'(flags_r), 128'(e.flags));
      end
    end
  end

  initial begin
    int           t;
    int           n;
    logic [127:0] s;
    logic [127:0] ef;
    logic [127:0] er;
    logic [15:0]  ramp_tab [9];
    logic [15:0]  b3_tab [4];
    logic [15:0]  b1_tab [3];

    ramp_tab = '{16'h0100, 16'h0140, 16'h0180, 16'h01C0, 16'h0200,
                 16'h0240, 16'h0280, 16'h02C0, 16'h0300};
    b3_tab   = '{16'h0010, 16'h0014, 16'h0018, 16'h001C};
    b1_tab   = '{16'h0010, 16'h000C, 16'h0008};

    rst         = 1'b1;
    en          = 1'b0;
    gains_valid = 1'b0;
    gains       = 64'h0404040404040404;
    in_valid    = 1'b0;
    filter_ins  = '0;
    sat_clear   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_in_ready_floor", 128'(in_ready_f), 128'd1);
    check("rst_in_ready_round", 128'(in_ready_r), 128'd1);
    check("rst_out_valid", 128'(out_valid_f), 128'd0);
    check("rst_amp_floor", amp_f, 128'd0);
    check("rst_amp_round", amp_r, 128'd0);
    check("rst_flags", 128'(flags_f), 128'd0);

    // Unity gain passes samples through; latency is accept + 9
    s = all16(16'h1234);
    send_frame(1'b1, s, s, s, 8'h00, 1'b1, t);

    // Band 0 target 12 ramps 4,5,...,12 over nine frames
    set_gains(64'h040404040404040C);
    for (int k = 0; k < 9; k++) begin
      s  = all16(16'h0100);
      ef = put16(s, 0, ramp_tab[k]);
      send_frame(1'b1, s, ef, ef, 8'h00, 1'b1, t);
    end

    // Band 3 target 8: ramp 4..7 then saturate both ways
    set_gains(64'h040404040804040C);
    for (int k = 0; k < 4; k++) begin
      s  = all16(16'h0010);
      ef = put16(put16(s, 0, 16'h0030), 3, b3_tab[k]);
      send_frame(1'b1, s, ef, ef, 8'h00, 1'b1, t);
    end
    s  = put16(all16(16'h0010), 3, 16'h7FFF);
    ef = put16(s, 0, 16'h0030);
    send_frame(1'b1, s, ef, ef, 8'h08, 1'b1, t);
    s  = put16(all16(16'h0010), 3, 16'h8000);
    ef = put16(s, 0, 16'h0030);
    send_frame(1'b1, s, ef, ef, 8'h08, 1'b1, t);

    // sat_clear while idle clears the sticky flags
    wait_idle();
    sat_clear = 1'b1;
    @(negedge clk);
    sat_clear = 1'b0;
    check("sat_clear_floor", 128'(flags_f), 128'd0);
    check("sat_clear_round", 128'(flags_r), 128'd0);

    // Band 1 target 1 (0.25): ramp 4,3,2, then rounding corner cases
    set_gains(64'h040404040804010C);
    for (int k = 0; k < 3; k++) begin
      s  = all16(16'h0010);
      ef = put16(put16(put16(s, 0, 16'h0030), 3, 16'h0020), 1, b1_tab[k]);
      send_frame(1'b1, s, ef, ef, 8'h00, 1'b1, t);
    end
    s  = put16(all16(16'h0010), 1, 16'h0003);
    ef = put16(put16(put16(s, 0, 16'h0030), 3, 16'h0020), 1, 16'h0000);
    er = put16(ef, 1, 16'h0001);
    send_frame(1'b1, s, ef, er, 8'h00, 1'b1, t);
    s  = put16(all16(16'h0010), 1, 16'hFFFD);
    ef = put16(put16(put16(s, 0, 16'h0030), 3, 16'h0020), 1, 16'hFFFF);
    send_frame(1'b1, s, ef, ef, 8'h00, 1'b1, t);

    // Bypass: samples pass unchanged and gain 8 on 0x7FFF does not flag
    s = put16(put16(all16(16'h0010), 3, 16'h7FFF), 1, 16'h0003);
    send_frame(1'b0, s, s, s, 8'h00, 1'b1, t);

    // Saturation on band 3 with sat_clear in the very same cycle: set wins
    s  = put16(all16(16'h0010), 3, 16'h7FFF);
    ef = put16(put16(s, 0, 16'h0030), 1, 16'h0004);
    send_frame(1'b1, s, ef, ef, 8'h08, 1'b1, t);
    while (cyc < t + 4) @(negedge clk);
    sat_clear = 1'b1;
    @(negedge clk);
    sat_clear = 1'b0;

    // Reset during band 4 of a frame: no output, everything back to reset
    s = all16(16'h0010);
    send_frame(1'b1, s, s, s, 8'h00, 1'b0, t);
    while (cyc < t + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready_floor", 128'(in_ready_f), 128'd1);
    check("post_rst_in_ready_round", 128'(in_ready_r), 128'd1);
    check("post_rst_amp", amp_f, 128'd0);
    check("post_rst_flags", 128'(flags_f), 128'd0);
    repeat (12) @(negedge clk);
    s = all16(16'h0100);
    send_frame(1'b1, s, s, s, 8'h00, 1'b1, t);

    // Drain the scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout actual=%0d required=0 frames pending", exp_q.size());
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
